uart_fifo_tx: RTL
=================

# uart_fifo_tx

Transmit-side drain engine that reads bytes from the 8-bit TX FIFO the piano writes into, and serializes them onto `FPGA_SERIAL_TX` as 8N1 UART frames (LSB first). It sits between the TX FIFO read port and the board serial pin. It fully replaces the ad-hoc `rd_en`/`valid` glue around the on-chip UART transmitter, so FIFO reads are paced by frame completion and no handshake is lost.

## Interface
- `CLOCK_FREQ`, 125_000_000, clock frequency in Hz
- `BAUD_RATE`, 115_200, serial bit rate
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `tx_enable`  in  1  when high, new frames may start; when low, the current frame completes and no further FIFO reads occur
- `fifo_empty`  in  1  TX FIFO empty flag
- `fifo_rd_en`  out  1  FIFO read strobe; exactly one cycle per byte
- `fifo_dout`  in  8  FIFO read data, valid on the cycle after `fifo_rd_en`
- `serial_out`  out  1  UART line; idles high
- `busy`  out  1  high from the `fifo_rd_en` cycle through the last stop-bit cycle
- `frames_sent`  out  16  count of completed frames; wraps from 0xFFFF to 0

## Operation
- `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE` (integer truncation), with a minimum of 2. The bit counter width is `$clog2(SYMBOL_EDGE_TIME)`.
- FSM states:
  - IDLE → FETCH when `tx_enable && !fifo_empty`. `fifo_rd_en` is asserted combinationally in this IDLE cycle only.
  - FETCH → SHIFT unconditionally after one cycle. In FETCH, `fifo_dout` is captured into a shift register `{1'b1, [parity,] data[7:0], 1'b0}`.
  - SHIFT holds each bit for `SYMBOL_EDGE_TIME` cycles. After the last (stop) bit it increments `frames_sent` and returns to IDLE.
- `serial_out` is a registered output driven from shift-register bit 0, and is 1 in IDLE and FETCH.
- `tx_enable` is sampled only in IDLE. Deasserting it mid-frame never truncates a frame.
- `fifo_empty` is ignored outside IDLE. A FIFO that becomes non-empty during a frame is serviced on the next IDLE cycle.
- Reset values: `serial_out`=1, `fifo_rd_en`=0, `busy`=0, `frames_sent`=0, state=IDLE.
- Reset asserted mid-frame: the line returns high immediately (asynchronously). The partial byte is discarded and is not re-read.

## Timing
- Cycle 0 (IDLE, non-empty, enabled): `fifo_rd_en`=1 and `busy`=1.
- Cycle 1 (FETCH): data captured.
- Cycle 2: `serial_out` falls (start bit).
- Frame duration on the line is 10·T cycles, where T = `SYMBOL_EDGE_TIME` (11·T with parity).
- `frames_sent` increments on the final cycle of the stop bit. `busy` falls the following cycle.
- Back-to-back bytes: the next `fifo_rd_en` comes one cycle after the return to IDLE. The gap between stop-bit end and the next start bit is exactly 3 cycles of high line.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - An even-parity bit (XOR of data[7:0]) is inserted between data[7] and the stop bit.
  - The frame is 11 bits and the shift register is 11 bits.
- `UART_TX_PARITY_EN` undefined: 8N1, 10-bit frame, and no parity logic is synthesized.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, FETCH, SHIFT)
  - the frame-length constants `UART_FRAME_BITS` (10/11), selected by the macro
  - the `symbol_edge_time(clock_freq, baud)` constant function, shared with the receiver
- One natural sub-module, `baud_tick`: a down-counter reloaded with `SYMBOL_EDGE_TIME-1` that emits a one-cycle `tick` at each bit boundary. It is cleared whenever the FSM is not in SHIFT.

## Test plan
Bench parameters: `CLOCK_FREQ`=1000, `BAUD_RATE`=100, giving T=10.
- Push 0x55 into an empty FIFO with `tx_enable`=1:
  - `fifo_rd_en` is high for exactly 1 cycle.
  - `serial_out` reads 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each held 10 cycles.
  - `frames_sent`=1.
- Push 0xA3, 0x0F back-to-back:
  - Exactly 2 reads occur.
  - The line is high for exactly 3 cycles between frames.
  - `frames_sent`=2.
- Drop `tx_enable` 25 cycles into a 0xFF frame while 2 more bytes are queued:
  - The current frame completes.
  - No further `fifo_rd_en` occurs until `tx_enable` returns high.
- Assert `rst` low during data bit 4:
  - `serial_out`=1 in the same cycle.
  - `busy`=0 and `frames_sent`=0.
  - After release, the next queued byte transmits cleanly.
- Force `frames_sent` to 0xFFFF via 65535 short frames (or by preload in sim), then send one byte: `frames_sent`=0x0000.
- With `UART_TX_PARITY_EN`, send 0x07: the parity bit is 1 and the frame lasts 110 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM states, frame length and baud-period helper.
// Frame length follows the UART_TX_PARITY_EN macro (11 bits with parity, 10 without).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT
    } tx_state_e;

`ifdef UART_TX_PARITY_EN
    localparam int UART_FRAME_BITS = 11;
`else
    localparam int UART_FRAME_BITS = 10;
`endif

    // Clock cycles per bit, floored at 2 so the baud counter is never zero-width.
    function automatic int symbol_edge_time(input int clock_freq, input int baud);
        int t;
        t = clock_freq / baud;
        return (t < 2) ? 2 : t;
    endfunction

endpackage

// File: rtl/uart_fifo_tx_if.sv
// Read-port bundle between the TX FIFO and the drain engine.
// master = engine (issues reads), slave = FIFO (supplies flag and data).
interface uart_fifo_tx_if;

    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_dout
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_dout
    );

endinterface

// File: rtl/uart_fifo_tx_baud_tick.sv
// Bit-period timer: one-cycle tick every T enabled cycles, held at reload while disabled.
module baud_tick #(
    parameter int T = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int          CNT_W  = $clog2(T);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(T - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= RELOAD;
        end else if (!enable || count == '0) begin
            count <= RELOAD;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = enable && (count == '0);

endmodule

// File: rtl/uart_fifo_tx.sv
// TX FIFO drain engine: pops one byte per frame and shifts it out as 8N1 (8E1 when
// UART_TX_PARITY_EN is defined), LSB first, with a one-cycle idle hold after each stop bit.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_enable,
    uart_fifo_tx_if.master        fifo,
    output logic                  serial_out,
    output logic                  busy,
    output logic [15:0]           frames_sent
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int BIT_W            = $clog2(UART_FRAME_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_FRAME_BITS - 1);

    tx_state_e                  state;
    tx_state_e                  state_next;
    logic [UART_FRAME_BITS-1:0] shreg;
    logic [BIT_W-1:0]           bit_idx;
    logic                       hold_off;
    logic                       start;
    logic                       tick;
    logic                       last_bit;

    function automatic logic [UART_FRAME_BITS-1:0] build_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    baud_tick #(
        .T(SYMBOL_EDGE_TIME)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (state == SHIFT),
        .tick   (tick)
    );

    // Reset gates the read strobe so no byte is popped while the engine is held.
    assign start    = rst && !hold_off && tx_enable && !fifo.fifo_empty;
    assign last_bit = (bit_idx == LAST_BIT);

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next      = state;
        fifo.fifo_rd_en = 1'b0;
        busy            = 1'b1;
        case (state)
            IDLE: begin
                busy = start;
                if (start) begin
                    fifo.fifo_rd_en = 1'b1;
                    state_next      = FETCH;
                end
            end
            FETCH: state_next = SHIFT;
            SHIFT: begin
                if (tick && last_bit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shift register refills with ones, so the line rests high outside a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg       <= '1;
            bit_idx     <= '0;
            hold_off    <= 1'b0;
            frames_sent <= '0;
        end else begin
            hold_off <= 1'b0;
            case (state)
                FETCH: begin
                    shreg   <= build_frame(fifo.fifo_dout);
                    bit_idx <= '0;
                end
                SHIFT: begin
                    if (tick) begin
                        shreg <= {1'b1, shreg[UART_FRAME_BITS-1:1]};
                        if (last_bit) begin
                            frames_sent <= frames_sent + 16'd1;
                            hold_off    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign serial_out = shreg[0];

endmodule
